// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state type, funct3 codes and byte-lane helpers for mem_access_ctrl
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Bits [3:0] are the first word's lanes, bits [7:4] spill into the next word.
    function automatic logic [7:0] byte_enable(input logic [1:0] offset, input logic [2:0] size);
        logic [7:0] mask;
        mask = (8'd1 << size) - 8'd1;
        return mask << offset;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - aligns an assembled 64-bit load word by byte offset and extends per funct3
module load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [63:0] din,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] dout
);
    logic [31:0] shifted;

    always_comb begin
        shifted = 32'(din >> {offset, 3'b000});
        case (funct3)
            F3_B:    dout = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    dout = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   dout = {24'b0, shifted[7:0]};
            F3_HU:   dout = {16'b0, shifted[15:0]};
            default: dout = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer over req/gnt/rvalid; MEM_ACCESS_MISALIGN_EN splits word-crossing accesses
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       StoreData,
    output logic              Stall,
    output logic [31:0]       LoadData,
    output logic              Fault,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [3:0]        MemBe,
    output logic [31:0]       MemWdata,
    input  logic              MemGnt,
    input  logic              MemRvalid,
    input  logic [31:0]       MemRdata
);
    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t            state;
    logic [2:0]        f3_q, src_f3, size;
    logic [ADDR_W-1:0] addr_q, src_addr, word_addr;
    logic [31:0]       sdata_q, src_sdata, ld_q, ext_data;
    logic              fault_q, in_idle, legal, req_fault, last_beat;
    logic [CW-1:0]     tcnt;
    logic [7:0]        be;
    logic [63:0]       wide, asm_word;

    // In IDLE the lane/data math runs on the live inputs so the first request can be registered at once.
    assign in_idle   = (state == ST_IDLE);
    assign src_f3    = in_idle ? funct3 : f3_q;
    assign src_addr  = in_idle ? Addr : addr_q;
    assign src_sdata = in_idle ? StoreData : sdata_q;
    assign size      = access_size(src_f3);
    assign be        = byte_enable(src_addr[1:0], size);
    assign wide      = {32'b0, src_sdata} << {src_addr[1:0], 3'b000};
    assign word_addr = {src_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        legal = 1'b0;
        if (MemWrite)
            legal = funct3 inside {F3_B, F3_H, F3_W};
        else
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end

`ifdef MEM_ACCESS_MISALIGN_EN
    logic        phase;
    logic [31:0] buf0;
    assign last_beat = phase || (be[7:4] == 4'b0000);
    assign asm_word  = phase ? {MemRdata, buf0} : {32'b0, MemRdata};
    assign req_fault = (MemRead & MemWrite) | ~legal;
`else
    logic        misaligned;
    logic [35:0] unused_hi;
    assign misaligned = (size == 3'd2 && src_addr[0]) || (size == 3'd4 && src_addr[1:0] != 2'b00);
    assign last_beat  = 1'b1;
    assign asm_word   = {32'b0, MemRdata};
    assign req_fault  = (MemRead & MemWrite) | ~legal | misaligned;
    assign unused_hi  = {be[7:4], wide[63:32]};
`endif

    load_extend u_load_extend (
        .din    (asm_word),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .dout   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            f3_q     <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            ld_q     <= '0;
            fault_q  <= 1'b0;
            tcnt     <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemBe    <= '0;
            MemWdata <= '0;
`ifdef MEM_ACCESS_MISALIGN_EN
            phase    <= 1'b0;
            buf0     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (MemRead | MemWrite) begin
                    if (req_fault) begin
                        state   <= ST_DONE;
                        fault_q <= 1'b1;
                        ld_q    <= '0;
                    end else begin
                        f3_q     <= funct3;
                        addr_q   <= Addr;
                        sdata_q  <= StoreData;
                        state    <= ST_REQ;
                        MemReq   <= 1'b1;
                        MemWe    <= MemWrite;
                        MemAddr  <= word_addr;
                        MemBe    <= be[3:0];
                        MemWdata <= wide[31:0];
`ifdef MEM_ACCESS_MISALIGN_EN
                        phase    <= 1'b0;
`endif
                    end
                end
                ST_REQ: if (MemGnt) begin
                    MemReq <= 1'b0;
                    if (!MemWe) begin
                        state <= ST_WAIT;
                        tcnt  <= '0;
                    end else if (last_beat) begin
                        state <= ST_DONE;
                        ld_q  <= '0;
                    end
`ifdef MEM_ACCESS_MISALIGN_EN
                    else begin
                        phase    <= 1'b1;
                        MemReq   <= 1'b1;
                        MemAddr  <= word_addr + ADDR_W'(4);
                        MemBe    <= be[7:4];
                        MemWdata <= wide[63:32];
                    end
`endif
                end
                ST_WAIT: if (MemRvalid) begin
                    if (last_beat) begin
                        state <= ST_DONE;
                        ld_q  <= ext_data;
                    end
`ifdef MEM_ACCESS_MISALIGN_EN
                    else begin
                        buf0     <= MemRdata;
                        phase    <= 1'b1;
                        state    <= ST_REQ;
                        MemReq   <= 1'b1;
                        MemAddr  <= word_addr + ADDR_W'(4);
                        MemBe    <= be[7:4];
                        MemWdata <= wide[63:32];
                    end
`endif
                end else if (tcnt == CW'(WAIT_MAX - 1)) begin
                    state   <= ST_DONE;
                    fault_q <= 1'b1;
                    ld_q    <= '0;
                end else begin
                    tcnt <= tcnt + CW'(1);
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    fault_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Stall    = rst_n & ((in_idle & (MemRead | MemWrite)) | state == ST_REQ | state == ST_WAIT);
    assign LoadData = ld_q;
    assign Fault    = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl (MEM_ACCESS_MISALIGN_EN selects split expectations)
module tb_mem_access_ctrl;
    localparam int WAIT_MAX = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] Addr = '0, StoreData = '0;
    logic        Stall, Fault, MemReq, MemWe;
    logic [31:0] LoadData, MemAddr, MemWdata;
    logic [3:0]  MemBe;
    logic        MemGnt = 1'b0, MemRvalid = 1'b0;
    logic [31:0] MemRdata = '0;

    mem_access_ctrl #(.ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .Addr(Addr), .StoreData(StoreData), .Stall(Stall), .LoadData(LoadData), .Fault(Fault),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe), .MemWdata(MemWdata),
        .MemGnt(MemGnt), .MemRvalid(MemRvalid), .MemRdata(MemRdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } req_t;
    typedef struct packed { logic [31:0] data; logic fault; logic [15:0] stalls; } rsp_t;

    req_t        exp_req[$];
    rsp_t        exp_rsp[$];
    logic [31:0] rd_words[$];
    req_t        cur_req;
    rsp_t        cur_rsp;
    int          total = 0, bad = 0;
    int          gnt_delay = 0, gcnt = 0, stall_cnt = 0, done_cnt = 0;
    bit          no_rv = 1'b0, rv_pend = 1'b0, inject_rv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected by scoreboard", name);
    endtask

    task automatic push_req(input logic [31:0] a, input logic [3:0] b, input logic w, input logic [31:0] d);
        exp_req.push_back({a, b, w, d});
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic f, input int s);
        exp_rsp.push_back({d, f, 16'(s)});
    endtask

    // Memory responder and monitor: both act on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt = 0;
            MemGnt    = 1'b0;
            MemRvalid = 1'b0;
            rv_pend   = 1'b0;
            gcnt      = 0;
        end else begin
            if (inject_rv) begin
                MemRvalid = 1'b1;
                MemRdata  = 32'hDEAD_BEEF;
                inject_rv = 1'b0;
            end else if (rv_pend && rd_words.size() > 0) begin
                MemRvalid = 1'b1;
                MemRdata  = rd_words.pop_front();
            end else begin
                MemRvalid = 1'b0;
            end
            rv_pend = 1'b0;
            MemGnt  = 1'b0;
            if (MemReq) begin
                if (exp_req.size() == 0) begin
                    fail_now("unexpected_req");
                end else begin
                    cur_req = exp_req[0];
                    check("req_addr", MemAddr, cur_req.addr);
                    check("req_be", {28'b0, MemBe}, {28'b0, cur_req.be});
                    check("req_we", {31'b0, MemWe}, {31'b0, cur_req.we});
                    check("req_wdata", MemWdata, cur_req.wdata);
                    if (gcnt == gnt_delay) begin
                        MemGnt = 1'b1;
                        gcnt   = 0;
                        void'(exp_req.pop_front());
                        if (!MemWe && !no_rv) rv_pend = 1'b1;
                    end else begin
                        gcnt++;
                    end
                end
            end
            if (Stall) stall_cnt++;
            if ((MemRead | MemWrite) && !Stall) begin
                if (exp_rsp.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    cur_rsp = exp_rsp.pop_front();
                    check("load_data", LoadData, cur_rsp.data);
                    check("fault", {31'b0, Fault}, {31'b0, cur_rsp.fault});
                    check("stall_cycles", 32'(stall_cnt), {16'b0, cur_rsp.stalls});
                end
                stall_cnt = 0;
                done_cnt++;
            end
        end
    end

    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int gd, input bit norv);
        int start;
        int budget;
        start     = done_cnt;
        budget    = 0;
        gnt_delay = gd;
        no_rv     = norv;
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        Addr      = a;
        StoreData = sd;
        while (done_cnt == start && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        if (done_cnt == start) fail_now("done_timeout");
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        no_rv    = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_memreq", {31'b0, MemReq}, 32'd0);
        check("rst_memwe", {31'b0, MemWe}, 32'd0);
        check("rst_memaddr", MemAddr, 32'd0);
        check("rst_membe", {28'b0, MemBe}, 32'd0);
        check("rst_memwdata", MemWdata, 32'd0);
        check("rst_loaddata", LoadData, 32'd0);
        check("rst_fault", {31'b0, Fault}, 32'd0);
        check("rst_stall", {31'b0, Stall}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // LW aligned
        push_req(32'h100, 4'b1111, 1'b0, 32'h0);
        rd_words.push_back(32'h8081_8283);
        push_rsp(32'h8081_8283, 1'b0, 3);
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 0);

        // LB / LBU at top lane
        push_req(32'h100, 4'b1000, 1'b0, 32'h0);
        rd_words.push_back(32'h8012_3456);
        push_rsp(32'hFFFF_FF80, 1'b0, 3);
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 0);
        push_req(32'h100, 4'b1000, 1'b0, 32'h0);
        rd_words.push_back(32'h8012_3456);
        push_rsp(32'h0000_0080, 1'b0, 3);
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 0, 0);

        // SH with grant delayed 3 cycles
        push_req(32'h200, 4'b1100, 1'b1, 32'hABCD_0000);
        push_rsp(32'h0, 1'b0, 5);
        run_op(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 0);

        // SW and SB
        push_req(32'h300, 4'b1111, 1'b1, 32'hDEAD_BEEF);
        push_rsp(32'h0, 1'b0, 2);
        run_op(0, 1, 3'b010, 32'h300, 32'hDEAD_BEEF, 0, 0);
        push_req(32'h300, 4'b0010, 1'b1, 32'h0000_A500);
        push_rsp(32'h0, 1'b0, 2);
        run_op(0, 1, 3'b000, 32'h301, 32'h0000_00A5, 0, 0);

        // LH / LHU
        push_req(32'h100, 4'b1100, 1'b0, 32'h0);
        rd_words.push_back(32'h8001_7777);
        push_rsp(32'hFFFF_8001, 1'b0, 3);
        run_op(1, 0, 3'b001, 32'h102, 32'h0, 0, 0);
        push_req(32'h104, 4'b1100, 1'b0, 32'h0);
        rd_words.push_back(32'hFFFE_1234);
        push_rsp(32'h0000_FFFE, 1'b0, 3);
        run_op(1, 0, 3'b101, 32'h106, 32'h0, 0, 0);

`ifdef MEM_ACCESS_MISALIGN_EN
        push_req(32'h100, 4'b1110, 1'b0, 32'h0);
        push_req(32'h104, 4'b0001, 1'b0, 32'h0);
        rd_words.push_back(32'h4433_2211);
        rd_words.push_back(32'h8877_6655);
        push_rsp(32'h5544_3322, 1'b0, 5);
        run_op(1, 0, 3'b010, 32'h101, 32'h0, 0, 0);
        push_req(32'h100, 4'b1100, 1'b1, 32'hCCDD_0000);
        push_req(32'h104, 4'b0011, 1'b1, 32'h0000_AABB);
        push_rsp(32'h0, 1'b0, 3);
        run_op(0, 1, 3'b010, 32'h102, 32'hAABB_CCDD, 0, 0);
        push_req(32'h100, 4'b0110, 1'b0, 32'h0);
        rd_words.push_back(32'h00AB_CD00);
        push_rsp(32'hFFFF_ABCD, 1'b0, 3);
        run_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 0);
`else
        push_rsp(32'h0, 1'b1, 1);
        run_op(1, 0, 3'b010, 32'h101, 32'h0, 0, 0);
        push_rsp(32'h0, 1'b1, 1);
        run_op(0, 1, 3'b010, 32'h102, 32'hAABB_CCDD, 0, 0);
        push_rsp(32'h0, 1'b1, 1);
        run_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 0);
`endif

        // Faults detected in IDLE: read+write, illegal store size, illegal load code
        push_rsp(32'h0, 1'b1, 1);
        run_op(1, 1, 3'b010, 32'h100, 32'h0, 0, 0);
        push_rsp(32'h0, 1'b1, 1);
        run_op(0, 1, 3'b100, 32'h100, 32'h55, 0, 0);
        push_rsp(32'h0, 1'b1, 1);
        run_op(1, 0, 3'b011, 32'h100, 32'h0, 0, 0);

        // Missing rvalid: IDLE + REQ + WAIT_MAX WAIT cycles
        push_req(32'h400, 4'b1111, 1'b0, 32'h0);
        push_rsp(32'h0, 1'b1, WAIT_MAX + 2);
        run_op(1, 0, 3'b010, 32'h400, 32'h0, 0, 1);

        // Reset while in WAIT, then a stray rvalid in IDLE
        push_req(32'h500, 4'b1111, 1'b0, 32'h0);
        no_rv    = 1'b1;
        MemRead  = 1'b1;
        funct3   = 3'b010;
        Addr     = 32'h500;
        repeat (2) @(posedge clk);
        #1;
        check("wait_stall", {31'b0, Stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_memreq", {31'b0, MemReq}, 32'd0);
        check("rst_mid_stall", {31'b0, Stall}, 32'd0);
        MemRead = 1'b0;
        no_rv   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        inject_rv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("late_rv_stall", {31'b0, Stall}, 32'd0);
        check("late_rv_memreq", {31'b0, MemReq}, 32'd0);
        check("late_rv_fault", {31'b0, Fault}, 32'd0);
        check("late_rv_loaddata", LoadData, 32'd0);
        push_req(32'h500, 4'b1111, 1'b0, 32'h0);
        rd_words.push_back(32'h1122_3344);
        push_rsp(32'h1122_3344, 1'b0, 3);
        run_op(1, 0, 3'b010, 32'h500, 32'h0, 0, 0);

        repeat (2) @(posedge clk);
        check("req_queue_drained", 32'(exp_req.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
